usm_rd_credit_limiter: RTL

//  Per-channel outstanding-read credit limiter between kernel USM masters and the host clock-crossing bridge.

---
 rtl/usm_rd_credit_limiter_pkg.sv | 8 +
 rtl/usm_rd_credit_limiter_if.sv | 19 +
 rtl/usm_rd_credit_limiter_chan.sv | 74 +++++++
 rtl/usm_rd_credit_limiter.sv | 45 ++++
 4 files changed

// File: rtl/usm_rd_credit_limiter_pkg.sv
// usm_rd_credit_limiter_pkg: shared limits and per-channel FSM state type
package usm_rd_credit_limiter_pkg;
   localparam int USM_CCB_RESPONSE_FIFO_DEPTH = 256;
   localparam int USM_RD_LIMIT_MAX = USM_CCB_RESPONSE_FIFO_DEPTH;
   localparam int USM_NUM_CHANNELS = 2;
   localparam int USM_BURSTCOUNT_W = 5;
   typedef enum logic [1:0] {URC_RUN, URC_DRAIN, URC_DRAINED} usm_rd_credit_state_t;
endpackage

// File: rtl/usm_rd_credit_limiter_if.sv
// usm_rd_credit_limiter_if: command handshake and response valid for all channels
interface usm_rd_credit_limiter_if
   import usm_rd_credit_limiter_pkg::*;
#(
   parameter int NC = USM_NUM_CHANNELS,
   parameter int BW = USM_BURSTCOUNT_W
);
   logic [NC-1:0]    s_read, s_write, s_waitrequest, s_readdatavalid;
   logic [NC-1:0]    m_read, m_write, m_waitrequest, m_readdatavalid;
   logic [NC*BW-1:0] s_burstcount;
   modport master (
      output s_read, s_write, s_burstcount, m_waitrequest, m_readdatavalid,
      input  s_waitrequest, s_readdatavalid, m_read, m_write
   );
   modport slave (
      input  s_read, s_write, s_burstcount, m_waitrequest, m_readdatavalid,
      output s_waitrequest, s_readdatavalid, m_read, m_write
   );
endinterface

// File: rtl/usm_rd_credit_limiter_chan.sv
// usm_rd_credit_limiter_chan: one channel's read credit counter, gating, drain FSM and stats
module usm_rd_credit_limiter_chan
   import usm_rd_credit_limiter_pkg::*;
#(
   parameter int BW    = USM_BURSTCOUNT_W,
   parameter int MAX   = USM_RD_LIMIT_MAX,
   parameter int CNT_W = $clog2(MAX + 1)
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             s_read_i,
   input  logic             s_write_i,
   input  logic [BW-1:0]    burstcount_i,
   input  logic             m_waitrequest_i,
   input  logic             m_readdatavalid_i,
   output logic             s_waitrequest_o,
   output logic             m_read_o,
   output logic             m_write_o,
   input  logic [CNT_W-1:0] cfg_limit_i,
   input  logic             drain_req_i,
   output logic             drained_o,
   output logic [CNT_W-1:0] outstanding_o,
   output logic [CNT_W-1:0] peak_o,
   output logic [31:0]      stall_cycles_o,
   output logic             underflow_err_o
);
   localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX);
   usm_rd_credit_state_t state_q, state_d;
   logic [CNT_W-1:0] limit_q, limit_d, out_q, out_d, peak_q;
   logic [CNT_W:0]   sum, out_nxt;
   logic [31:0]      stall_q;
   logic             uf_q, credit_blk, blk_rd, blk_wr, rd_acc, dec;
   always_comb begin
      limit_d = (cfg_limit_i == '0 || cfg_limit_i > MAX_C) ? MAX_C : cfg_limit_i;
      // an empty channel always admits one burst so an oversize burst cannot deadlock
      sum = {1'b0, out_q} + (CNT_W+1)'(burstcount_i);
      credit_blk = (sum > {1'b0, limit_q}) && (out_q != '0);
      blk_wr = state_q != URC_RUN;
      blk_rd = credit_blk || blk_wr;
      m_read_o = s_read_i & ~blk_rd;
      m_write_o = s_write_i & ~blk_wr;
      s_waitrequest_o = m_waitrequest_i | (s_read_i & blk_rd) | (s_write_i & blk_wr);
      rd_acc = m_read_o & ~m_waitrequest_i;
      dec = m_readdatavalid_i && out_q != '0;
      out_nxt = {1'b0, out_q} + (rd_acc ? (CNT_W+1)'(burstcount_i) : '0) - (CNT_W+1)'(dec);
      out_d = out_nxt[CNT_W-1:0];
      state_d = state_q;
      state_d = !drain_req_i ? URC_RUN :
                state_q == URC_RUN ? URC_DRAIN :
                (state_q == URC_DRAIN && out_q == '0) ? URC_DRAINED : state_q;
   end
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= URC_RUN;
         limit_q <= MAX_C;
         out_q   <= '0;
         peak_q  <= '0;
         stall_q <= '0;
         uf_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         limit_q <= limit_d;
         out_q   <= out_d;
         if (out_d > peak_q) peak_q <= out_d;
         if (s_read_i && credit_blk && stall_q != '1) stall_q <= stall_q + 32'd1;
         if (m_readdatavalid_i && out_q == '0) uf_q <= 1'b1;
      end
   end
   assign drained_o       = state_q == URC_DRAINED;
   assign outstanding_o   = out_q;
   assign peak_o          = peak_q;
   assign stall_cycles_o  = stall_q;
   assign underflow_err_o = uf_q;
endmodule

// File: rtl/usm_rd_credit_limiter.sv
// usm_rd_credit_limiter: per-channel outstanding-read credit limiter for USM masters
module usm_rd_credit_limiter
   import usm_rd_credit_limiter_pkg::*;
#(
   parameter int NUM_CHANNELS     = USM_NUM_CHANNELS,
   parameter int BURSTCOUNT_WIDTH = USM_BURSTCOUNT_W,
   parameter int MAX_OUTSTANDING  = USM_RD_LIMIT_MAX,
   localparam int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
   input  logic                          clk,
   input  logic                          reset_n,
   usm_rd_credit_limiter_if.slave        bus,
   input  logic [NUM_CHANNELS*CNT_W-1:0] cfg_limit_i,
   input  logic [NUM_CHANNELS-1:0]       drain_req_i,
   output logic [NUM_CHANNELS-1:0]       drained_o,
   output logic [NUM_CHANNELS*CNT_W-1:0] outstanding_o,
   output logic [NUM_CHANNELS*CNT_W-1:0] peak_outstanding_o,
   output logic [NUM_CHANNELS*32-1:0]    stall_cycles_o,
   output logic [NUM_CHANNELS-1:0]       underflow_err_o
);
   assign bus.s_readdatavalid = bus.m_readdatavalid;
   for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_ch
      usm_rd_credit_limiter_chan #(
         .BW(BURSTCOUNT_WIDTH), .MAX(MAX_OUTSTANDING), .CNT_W(CNT_W)
      ) u_chan (
         .clk               (clk),
         .reset_n           (reset_n),
         .s_read_i          (bus.s_read[i]),
         .s_write_i         (bus.s_write[i]),
         .burstcount_i      (bus.s_burstcount[i*BURSTCOUNT_WIDTH +: BURSTCOUNT_WIDTH]),
         .m_waitrequest_i   (bus.m_waitrequest[i]),
         .m_readdatavalid_i (bus.m_readdatavalid[i]),
         .s_waitrequest_o   (bus.s_waitrequest[i]),
         .m_read_o          (bus.m_read[i]),
         .m_write_o         (bus.m_write[i]),
         .cfg_limit_i       (cfg_limit_i[i*CNT_W +: CNT_W]),
         .drain_req_i       (drain_req_i[i]),
         .drained_o         (drained_o[i]),
         .outstanding_o     (outstanding_o[i*CNT_W +: CNT_W]),
         .peak_o            (peak_outstanding_o[i*CNT_W +: CNT_W]),
         .stall_cycles_o    (stall_cycles_o[i*32 +: 32]),
         .underflow_err_o   (underflow_err_o[i])
      );
   end
endmodule
